bcd_updown_counter_n: RTL and testbench

Parametrised N-digit BCD up/down counter with pause, range limits, wrap or saturate mode and a terminal-count pulse. It generalises the two-digit 00-99 up/down/pause counter. It drives display and timer logic in the same clock domain, and multiple instances chain through Tc for wider counts.

---
 rtl/bcd_updown_counter_n.sv | 182 ++++++++++++++++++
 tb/tb_bcd_updown_counter_n.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with pause, MIN/MAX limits, wrap or saturate, and a terminal-count pulse.
// Optional parallel load (Load, LoadVal, LoadErr) is built only when the LOAD_EN macro is defined.
module bcd_updown_counter_n #(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MAX_VAL = 99,
    parameter int unsigned MIN_VAL = 0,
    parameter bit          WRAP    = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                UpOrDown,
    input  logic                pause,
`ifdef LOAD_EN
    input  logic                Load,
    input  logic [4*DIGITS-1:0] LoadVal,
    output logic                LoadErr,
`endif
    output logic [4*DIGITS-1:0] Count,
    output logic                Tc,
    output logic                AtMax,
    output logic                AtMin
);

    localparam int unsigned W = 4 * DIGITS;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < int'(n); i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int unsigned val);
        logic [W-1:0] res;
        int unsigned  rem;
        res = '0;
        rem = val;
        for (int i = 0; i < int'(DIGITS); i++) begin
            res[4*i +: 4] = 4'(rem % 10);
            rem = rem / 10;
        end
        return res;
    endfunction

    // Illegal parameter sets stop elaboration rather than producing a broken counter.
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("bcd_updown_counter_n: DIGITS must be in 1..8");
    end
    if (MIN_VAL >= MAX_VAL) begin : g_bad_order
        $error("bcd_updown_counter_n: MIN_VAL must be below MAX_VAL");
    end
    if (longint'(MAX_VAL) > pow10(DIGITS) - 1) begin : g_bad_max
        $error("bcd_updown_counter_n: MAX_VAL does not fit in DIGITS BCD digits");
    end

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);
    localparam logic [W-1:0] MIN_BCD = to_bcd(MIN_VAL);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W-1:0] count_inc;
    logic [W-1:0] count_dec;
    logic         tc_q;
    logic         tc_d;
    logic         at_max;
    logic         at_min;

    assign at_max = (count_q == MAX_BCD);
    assign at_min = (count_q == MIN_BCD);

    // Ripple carry/borrow across all digits within a single cycle; digits only ever wrap 9<->0.
    always_comb begin : bcd_step
        logic carry;
        logic borrow;
        count_inc = count_q;
        count_dec = count_q;
        carry     = 1'b1;
        borrow    = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    count_dec[4*i +: 4] = 4'd9;
                end else begin
                    count_dec[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
    end

`ifdef LOAD_EN
    logic load_digits_ok;
    logic load_ok;
    logic err_q;
    logic err_d;

    always_comb begin
        load_digits_ok = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (LoadVal[4*i +: 4] > 4'd9) begin
                load_digits_ok = 1'b0;
            end
        end
    end

    // With every digit valid, BCD ordering matches numeric ordering, so plain vector compares suffice.
    assign load_ok = load_digits_ok
                   && ((LoadVal > MIN_BCD) || (LoadVal == MIN_BCD))
                   && ((LoadVal < MAX_BCD) || (LoadVal == MAX_BCD));
`endif

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
`ifdef LOAD_EN
        err_d   = 1'b0;
        if (Load) begin
            if (load_ok) begin
                count_d = LoadVal;
            end else begin
                err_d = 1'b1;
            end
        end else
`endif
        if (!pause) begin
            if (UpOrDown) begin
                if (at_max) begin
                    if (WRAP) begin
                        count_d = MIN_BCD;
                        tc_d    = 1'b1;
                    end
                end else begin
                    count_d = count_inc;
                end
            end else begin
                if (at_min) begin
                    if (WRAP) begin
                        count_d = MAX_BCD;
                        tc_d    = 1'b1;
                    end
                end else begin
                    count_d = count_dec;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            count_q <= MIN_BCD;
            tc_q    <= 1'b0;
`ifdef LOAD_EN
            err_q   <= 1'b0;
`endif
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
`ifdef LOAD_EN
            err_q   <= err_d;
`endif
        end
    end

    assign Count = count_q;
    assign Tc    = tc_q;
    assign AtMax = at_max;
    assign AtMin = at_min;
`ifdef LOAD_EN
    assign LoadErr = err_q;
`endif

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Scoreboard bench for bcd_updown_counter_n: three configurations driven side by side,
// expectations from an integer-valued reference model, checked by a separate monitor.
module tb_bcd_updown_counter_n;

    localparam int N = 3;

    // Instance configurations: default 00-99 wrap, 05-12 saturate, 3-digit 000-999 wrap.
    int lo [N] = '{0, 5, 0};
    int hi [N] = '{99, 12, 999};
    int wr [N] = '{1, 0, 1};
    int dg [N] = '{2, 2, 3};

    logic Clk = 1'b0;
    always #10 Clk = ~Clk;

    logic [N-1:0] rst_n;
    logic [N-1:0] up;
    logic [N-1:0] pz;
    logic [N-1:0] ld;
    logic [11:0]  lval [N];

    logic [7:0]   cnt0;
    logic [7:0]   cnt1;
    logic [11:0]  cnt2;
    logic [N-1:0] tc_o;
    logic [N-1:0] amax_o;
    logic [N-1:0] amin_o;
`ifdef LOAD_EN
    logic [N-1:0] lerr_o;
`endif

    bcd_updown_counter_n #(.DIGITS(2), .MAX_VAL(99), .MIN_VAL(0), .WRAP(1'b1)) dut0 (
        .Clk(Clk), .Rst_n(rst_n[0]), .UpOrDown(up[0]), .pause(pz[0]),
`ifdef LOAD_EN
        .Load(ld[0]), .LoadVal(lval[0][7:0]), .LoadErr(lerr_o[0]),
`endif
        .Count(cnt0), .Tc(tc_o[0]), .AtMax(amax_o[0]), .AtMin(amin_o[0])
    );

    bcd_updown_counter_n #(.DIGITS(2), .MAX_VAL(12), .MIN_VAL(5), .WRAP(1'b0)) dut1 (
        .Clk(Clk), .Rst_n(rst_n[1]), .UpOrDown(up[1]), .pause(pz[1]),
`ifdef LOAD_EN
        .Load(ld[1]), .LoadVal(lval[1][7:0]), .LoadErr(lerr_o[1]),
`endif
        .Count(cnt1), .Tc(tc_o[1]), .AtMax(amax_o[1]), .AtMin(amin_o[1])
    );

    bcd_updown_counter_n #(.DIGITS(3), .MAX_VAL(999), .MIN_VAL(0), .WRAP(1'b1)) dut2 (
        .Clk(Clk), .Rst_n(rst_n[2]), .UpOrDown(up[2]), .pause(pz[2]),
`ifdef LOAD_EN
        .Load(ld[2]), .LoadVal(lval[2]), .LoadErr(lerr_o[2]),
`endif
        .Count(cnt2), .Tc(tc_o[2]), .AtMax(amax_o[2]), .AtMin(amin_o[2])
    );

    typedef struct packed {
        logic [N-1:0][11:0] cnt;
        logic [N-1:0]       tc;
        logic [N-1:0]       amax;
        logic [N-1:0]       amin;
        logic [N-1:0]       lerr;
    } exp_t;

    exp_t exp_q [$];
    int   val [N];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        int          x;
        r = '0;
        x = v;
        for (int d = 0; d < 3; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Reference model: the count is a plain integer moved by the counting rules.
    task automatic push_expected();
        exp_t e;
        e = '0;
        for (int i = 0; i < N; i++) begin
            logic t;
            logic le;
            int   lv;
            bit   ok;
            t  = 1'b0;
            le = 1'b0;
            if (!rst_n[i]) begin
                val[i] = lo[i];
            end else if (ld[i]) begin
                lv = 0;
                ok = 1'b1;
                for (int d = dg[i] - 1; d >= 0; d--) begin
                    if (int'(lval[i][4*d +: 4]) > 9) ok = 1'b0;
                    lv = lv * 10 + int'(lval[i][4*d +: 4]);
                end
                if (ok && lv >= lo[i] && lv <= hi[i]) val[i] = lv;
                else le = 1'b1;
            end else if (!pz[i]) begin
                if (up[i]) begin
                    if (val[i] == hi[i]) begin
                        if (wr[i] != 0) begin
                            val[i] = lo[i];
                            t = 1'b1;
                        end
                    end else begin
                        val[i] = val[i] + 1;
                    end
                end else begin
                    if (val[i] == lo[i]) begin
                        if (wr[i] != 0) begin
                            val[i] = hi[i];
                            t = 1'b1;
                        end
                    end else begin
                        val[i] = val[i] - 1;
                    end
                end
            end
            e.cnt[i]  = to_bcd(val[i]);
            e.tc[i]   = t;
            e.amax[i] = (val[i] == hi[i]);
            e.amin[i] = (val[i] == lo[i]);
            e.lerr[i] = le;
        end
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic r, input logic u, input logic p,
                                  input logic l, input logic [11:0] lv);
        @(negedge Clk);
        for (int i = 0; i < N; i++) begin
            rst_n[i] = r;
            up[i]    = u;
            pz[i]    = p;
            ld[i]    = l;
            lval[i]  = (dg[i] == 2) ? {4'h0, lv[7:0]} : lv;
        end
        push_expected();
    endtask

    task automatic apply_random(input int up_pct);
        @(negedge Clk);
        for (int i = 0; i < N; i++) begin
            logic [11:0] lv;
            rst_n[i] = ($urandom_range(0, 99) != 0);
            up[i]    = ($urandom_range(0, 99) < up_pct);
            pz[i]    = ($urandom_range(0, 5) == 0);
`ifdef LOAD_EN
            ld[i]    = ($urandom_range(0, 7) == 0);
`else
            ld[i]    = 1'b0;
`endif
            if ($urandom_range(0, 1) == 0) begin
                lv = to_bcd($urandom_range(lo[i], hi[i]));
            end else begin
                lv = '0;
                for (int d = 0; d < dg[i]; d++) begin
                    lv[4*d +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15))
                                                                : 4'($urandom_range(0, 9));
                end
            end
            lval[i] = lv;
        end
        push_expected();
    endtask

    task automatic check_output(input string nm, input int i,
                                input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s inst%0d: got %h expected %h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Monitor: one registered result per edge, compared mid-cycle against the oldest expectation.
    initial begin
        exp_t        e;
        logic [11:0] act;
        forever begin
            @(posedge Clk);
            #5;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < N; i++) begin
                    case (i)
                        0:       act = {4'h0, cnt0};
                        1:       act = {4'h0, cnt1};
                        default: act = cnt2;
                    endcase
                    check_output("count", i, act, e.cnt[i]);
                    check_output("tc",    i, {11'd0, tc_o[i]},   {11'd0, e.tc[i]});
                    check_output("atmax", i, {11'd0, amax_o[i]}, {11'd0, e.amax[i]});
                    check_output("atmin", i, {11'd0, amin_o[i]}, {11'd0, e.amin[i]});
`ifdef LOAD_EN
                    check_output("loaderr", i, {11'd0, lerr_o[i]}, {11'd0, e.lerr[i]});
`endif
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n = '0;
        up    = '1;
        pz    = '0;
        ld    = '0;
        for (int i = 0; i < N; i++) lval[i] = '0;
        for (int i = 0; i < N; i++) val[i] = 0;

        repeat (2)   apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        repeat (101) apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);

        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
        repeat (3)   apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 12'h000);

        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        repeat (45)  apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        repeat (3)   apply_stimulus(1'b1, 1'b1, 1'b1, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);

`ifdef LOAD_EN
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'h057);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'h05A);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 12'h012);
        apply_stimulus(1'b1, 1'b0, 1'b1, 1'b1, 12'h0F3);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 12'h099);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
`endif

        repeat (5)   apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 12'h000);
        repeat (2)   apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 12'h000);

        repeat (300) apply_random(80);
        repeat (300) apply_random(20);
        repeat (200) apply_random(50);

        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge Clk);
            guard++;
        end
        repeat (2) @(posedge Clk);
        #6;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
